// File: rtl/sdft_sample_feeder_if.sv
// Sample/start/ready handshake between the feeder (master) and sdft (slave).
interface sdft_sample_feeder_if #(
  parameter int unsigned data_width = 8
);
  logic signed [data_width-1:0] sample;
  logic                         start;
  logic                         ready;

  modport master (output sample, output start, input ready);
  modport slave  (input sample, input start, output ready);
endinterface

// File: rtl/sdft_sample_feeder.sv
// Buffers strobed samples in a small FIFO and feeds them one at a time to sdft.
// Optional request timeout is built when SDFT_FEEDER_TIMEOUT_EN is defined.
module sdft_sample_feeder #(
  parameter int unsigned data_width     = 8,
  parameter int unsigned fifo_depth     = 4,
  parameter int unsigned timeout_cycles = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [data_width-1:0]  in_sample,
  input  logic                          in_valid,
  input  logic                          clear_flags,
  sdft_sample_feeder_if.master          sdft,
  output logic [$clog2(fifo_depth):0]   level,
  output logic                          overflow,
  output logic                          timeout,
  output logic [15:0]                   sent
);

  localparam int unsigned PtrW = $clog2(fifo_depth);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] Full = LvlW'(fifo_depth);

  typedef enum logic [1:0] {StIdle, StReq, StBusy} state_e;

  logic [data_width-1:0] mem_q [fifo_depth];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]       level_q;
  logic                  overflow_q;
  state_e                state_q;
  logic                  start_q;
  logic [data_width-1:0] sample_q;
  logic [15:0]           sent_q;
  logic                  pop, push, drop, tmo_hit;

  // A pop in the same cycle frees the slot a push on a full FIFO needs.
  always_comb begin
    pop  = (state_q == StIdle) && (level_q != '0) && sdft.ready;
    push = in_valid && ((level_q != Full) || pop);
    drop = in_valid && !push;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_sample;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_q + LvlW'(push) - LvlW'(pop);
      if (clear_flags)  overflow_q <= 1'b0;
      else if (drop)    overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      start_q  <= 1'b0;
      sample_q <= '0;
      sent_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_q  <= StReq;
            start_q  <= 1'b1;
            sample_q <= mem_q[rd_ptr_q];
          end
        end
        StReq: begin
          if (!sdft.ready) begin
            state_q <= StBusy;
            start_q <= 1'b0;
          end else if (tmo_hit) begin
            // Abandoned request: the sample is discarded, not re-queued.
            state_q <= StIdle;
            start_q <= 1'b0;
          end
        end
        StBusy: begin
          if (sdft.ready) begin
            state_q <= StIdle;
            sent_q  <= sent_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SDFT_FEEDER_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(timeout_cycles + 1);

  logic [TmrW-1:0] tmr_q;
  logic            timeout_q;

  assign tmo_hit = (state_q == StReq) && sdft.ready && (tmr_q == TmrW'(timeout_cycles - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      tmr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state_q == StReq) && sdft.ready && !tmo_hit) tmr_q <= tmr_q + TmrW'(1);
      else                                              tmr_q <= '0;
      if (clear_flags)  timeout_q <= 1'b0;
      else if (tmo_hit) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  assign sdft.sample = sample_q;
  assign sdft.start  = start_q;
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign sent        = sent_q;

endmodule

// File: doc/sdft_sample_feeder.md
# sdft_sample_feeder

Initiator side of the `start`/`ready` sample handshake used by `sdft`. It accepts signed samples from an acquisition source on a single-cycle strobe, buffers them in a small FIFO, and presents them one at a time to `sdft`. For each sample it raises `start` and then waits for the `sdft` busy/ready cycle to complete. The block sits between the ADC/sample source and `sdft` in the same clock domain.

## Interface
- `data_width`, 8, sample width in bits (two's complement)
- `fifo_depth`, 4, FIFO entries; power of two, ≥ 2
- `timeout_cycles`, 255, maximum cycles `start` may stay high unacknowledged (used only with `SDFT_FEEDER_TIMEOUT_EN`)

- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `in_sample`  in  `data_width`  signed sample from source
- `in_valid`  in  1  one-cycle strobe: push `in_sample`
- `clear_flags`  in  1  synchronous clear of `overflow` and `timeout`
- `sample`  out  `data_width`  signed sample to `sdft`; held stable from `start` rise until the next load
- `start`  out  1  request to `sdft`
- `ready`  in  1  from `sdft`; high = idle
- `level`  out  `$clog2(fifo_depth)+1`  FIFO occupancy
- `overflow`  out  1  sticky; a push was dropped
- `timeout`  out  1  sticky; a request was aborted (forced 0 without macro)
- `sent`  out  16  count of completed handshakes; wraps 0xFFFF→0

## Operation
- **FIFO**
  - Circular buffer with read and write pointers; `level` is registered.
  - A push on a full FIFO drops the sample and sets `overflow`; FIFO contents are unchanged.
  - A push and a pop in the same cycle when full: the pop frees a slot, the push is accepted, `level` is unchanged, and `overflow` stays clear.
  - A push and a pop in the same cycle when empty cannot occur, because a pop requires `level` > 0.
- **State machine** (states IDLE, REQ, BUSY)
  - IDLE: if `level` > 0 and `ready` = 1 → REQ. On that edge, `sample` ← FIFO head, pop, `start` ← 1.
  - REQ: if `ready` = 0 → BUSY, `start` ← 0.
  - BUSY: if `ready` = 1 → IDLE, `sent` ← `sent` + 1.
  - Leaving BUSY always passes through IDLE, so there is at least one idle cycle between handshakes.
- **Flags**
  - `clear_flags` has priority over a same-cycle set; the flag reads 0 after that edge.
- **Arithmetic**
  - Samples pass through bit-exact with no sign extension or scaling.
  - `sent` is a modulo-2^16 counter.

## Timing
- **Reset values:** `start` = 0, `sample` = 0, `level` = 0, `overflow` = 0, `timeout` = 0, `sent` = 0, state IDLE, both pointers 0.
- **Push:** accepted at edge N; `level` increments at edge N and is visible in cycle N+1.
- **Earliest request:** `start` rises at the edge after a push, provided `ready` = 1 and the state is IDLE.
- **Request completion:** `start` falls exactly one edge after `ready` is first sampled low.
- **Handshake length:** minimum is 3 edges (IDLE→REQ→BUSY→IDLE) plus the `sdft` busy time.
- **Reset mid-handshake:** `start` = 0 after the reset edge. The popped sample is lost. The feeder issues no new `start` until it sees `ready` = 1, so it never double-requests a busy `sdft`.
- **`ready` low while IDLE** (e.g. `sdft` still busy after a feeder reset): the feeder stays in IDLE.

## Configuration
- **`SDFT_FEEDER_TIMEOUT_EN` defined:**
  - A counter runs while in REQ.
  - If `ready` is still 1 after `timeout_cycles` cycles in REQ, the feeder drops `start`, sets `timeout`, returns to IDLE and does not increment `sent`.
  - The sample is discarded, not re-queued.
- **`SDFT_FEEDER_TIMEOUT_EN` undefined:**
  - No counter is built and `timeout` is tied to 0.
  - REQ waits indefinitely.

## Test plan
- **Basic handshake:** after reset, push -100 with a `sdft` model (ready falls 2 cycles after `start`, busy 16 cycles) → `sample` = -100 with `start` = 1 one edge after the push; `start` low one edge after `ready` falls; `sent` = 1.
- **Stream:** push eight × -100 then eight × +100 back-to-back with `fifo_depth` = 4 → `sdft` receives exactly the samples that were accepted, in order; `overflow` = 1; `level` never exceeds 4.
- **Full with simultaneous pop:** with `level` = 4 and the FSM popping this cycle, push 7 → accepted, `level` stays 4, `overflow` = 0; 7 is eventually presented.
- **Reset mid-handshake:** assert `reset` = 0 in BUSY with `ready` low → `start` = 0 and `level` = 0; after release with `ready` low, no `start` until `ready` = 1.
- **Flags:** `clear_flags` in the same cycle as an overflowing push → `overflow` = 0; `sent` wraps from 0xFFFF to 0x0000 on the next completed handshake (preload via repeated handshakes or force).
- **Timeout (macro on, `timeout_cycles` = 10):** hold `ready` = 1 with `sdft` never responding → `start` high for 10 cycles then low, `timeout` = 1, `sent` unchanged.
